conv_writeback: RTL and testbench
=================================

CONV_WRITEBACK -- requirements
Module: conv_writeback

Interface
REQ-001 Parameter ACC_WIDTH, default 18: signed width of convolution accumulator input and of filter_bias.
REQ-002 Parameter OUT_WIDTH, default 8: unsigned width of each result word written to memory.
REQ-003 Parameter ADDR_WIDTH, default 16: memory address width.
REQ-004 Parameter FIFO_DEPTH, default 4: result buffer entries (power of two).
REQ-005 Port clk  in  1: single clock; all logic on rising edge.
REQ-006 Port rst  in  1: reset, synchronous, active-high.
REQ-007 Port start  in  1: one-cycle pulse; latches configuration and begins a run.
REQ-008 Port output_memory_offset  in  ADDR_WIDTH: base address of the result map.
REQ-009 Port output_count  in  16: number of results expected this run.
REQ-010 Port filter_bias  in  ACC_WIDTH: signed bias added to every accumulator value.
REQ-011 Port out_shift  in  4: arithmetic right-shift applied after bias.
REQ-012 Port acc_valid  in  1: upstream accumulator result present.
REQ-013 Port acc_data  in  ACC_WIDTH: signed accumulator result.
REQ-014 Port acc_ready  out  1: block accepts acc_data this cycle.
REQ-015 Port mem_we  out  1: write request.
REQ-016 Port mem_addr  out  ADDR_WIDTH: write address.
REQ-017 Port mem_wdata  out  OUT_WIDTH: write data.
REQ-018 Port mem_ready  in  1: memory accepts the write this cycle.
REQ-019 Port busy  out  1: run in progress.
REQ-020 Port done  out  1: one-cycle pulse when the run's final write is accepted.

Function
REQ-021 Accumulator transfer occurs on an edge where acc_valid and acc_ready are both high; memory write occurs on an edge where mem_we and mem_ready are both high.
REQ-022 State machine IDLE, RUN, FINISH; IDLE: busy=0, acc_ready=0, mem_we=0.
REQ-023 IDLE with start: latch offset, output_count, filter_bias, out_shift; clear accept and write counters; go RUN (or FINISH if output_count=0).
REQ-024 start in RUN or FINISH is ignored; configuration inputs are ignored outside the start cycle.
REQ-025 RUN: acc_ready = (FIFO not full) and (accepted count < latched output_count); FIFO full blocks even with a simultaneous pop.
REQ-026 Transform per accepted value, in order: sum = sign-extended acc_data + sign-extended filter_bias at ACC_WIDTH+1 bits; if sum<0 then 0; else sum >>> out_shift; if result > 2^OUT_WIDTH-1 then saturate to 2^OUT_WIDTH-1.
REQ-027 Transformed value is pushed into the FIFO on the transfer edge; mem_we is high from the next cycle at the earliest (latency 1 cycle, no bubbles when mem_ready=1).
REQ-028 mem_wdata is FIFO head; mem_addr = offset + write index, modulo 2^ADDR_WIDTH; write index increments per accepted write.
REQ-029 mem_we, mem_addr and mem_wdata hold stable while mem_ready is low.
REQ-030 When write count reaches output_count: go FINISH; FINISH asserts done for exactly one cycle, then IDLE.
REQ-031 busy is high in RUN and FINISH.
REQ-032 Results are written in acceptance order; none dropped or duplicated.

Reset
REQ-033 rst high at an edge: state IDLE, FIFO emptied, counters cleared, acc_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0.
REQ-034 rst mid-run aborts the run; buffered results are discarded and no done pulse is issued.
REQ-035 rst has priority over start in the same cycle.

Structure
REQ-036 Package conv_pkg holds ACC_WIDTH/OUT_WIDTH/ADDR_WIDTH defaults and the state encoding, shared with the accelerator.
REQ-037 One sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty, synchronous reset), holds the results.

Verification
REQ-038 filter_bias=100, out_shift=1, acc_data=200, count=1, offset=0x0040, mem_ready=1 -> one write addr 0x0040, data 150; done one cycle later.
REQ-039 acc_data=-150, bias=100 -> data 0; acc_data=1000, shift=0 -> data 255.
REQ-040 mem_ready held 0 for 10 cycles, acc_valid=1, count=8 -> acc_ready drops after 4 transfers, outputs stable; on release 8 writes in order, done.
REQ-041 offset=0xFFFE, count=3 -> addresses 0xFFFE, 0xFFFF, 0x0000.
REQ-042 output_count=0 start -> no writes, acc_ready never high, done pulse one cycle after start.
REQ-043 rst asserted after 2 of 5 writes -> all outputs at reset values next cycle, no done; subsequent start runs cleanly from write index 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared convolution-accelerator defaults and the writeback state encoding.
package conv_pkg;

  localparam int CONV_ACC_WIDTH  = 18;
  localparam int CONV_OUT_WIDTH  = 8;
  localparam int CONV_ADDR_WIDTH = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head; DEPTH must be a power of two >= 2.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/conv_writeback.sv
// Convolution writeback: bias, shift, clamp accumulator results and write them to memory.
module conv_writeback
  import conv_pkg::*;
#(
  parameter int ACC_WIDTH  = CONV_ACC_WIDTH,
  parameter int OUT_WIDTH  = CONV_OUT_WIDTH,
  parameter int ADDR_WIDTH = CONV_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] output_memory_offset,
  input  logic [15:0]           output_count,
  input  logic [ACC_WIDTH-1:0]  filter_bias,
  input  logic [3:0]            out_shift,
  input  logic                  acc_valid,
  input  logic [ACC_WIDTH-1:0]  acc_data,
  output logic                  acc_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [OUT_WIDTH-1:0]  mem_wdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ACC_WIDTH:0] SAT = (ACC_WIDTH+1)'((1 << OUT_WIDTH) - 1);

  logic [1:0]                  state;
  logic [ADDR_WIDTH-1:0]       offset_q;
  logic [15:0]                 count_q;
  logic [ACC_WIDTH-1:0]        bias_q;
  logic [3:0]                  shift_q;
  logic [15:0]                 acc_cnt;
  logic [15:0]                 wr_cnt;
  logic signed [ACC_WIDTH:0]   sum;
  logic signed [ACC_WIDTH:0]   shifted;
  logic [OUT_WIDTH-1:0]        result;
  logic [OUT_WIDTH-1:0]        fifo_dout;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        acc_fire;
  logic                        wr_fire;

  // One extra bit of headroom keeps acc + bias exact before the clamp.
  always_comb begin
    sum     = {acc_data[ACC_WIDTH-1], acc_data} + {bias_q[ACC_WIDTH-1], bias_q};
    shifted = sum >>> shift_q;
    if (sum[ACC_WIDTH])
      result = '0;
    else if (shifted > SAT)
      result = '1;
    else
      result = shifted[OUT_WIDTH-1:0];
  end

  assign acc_ready = (state == ST_RUN) && !fifo_full && (acc_cnt < count_q);
  assign mem_we    = (state == ST_RUN) && !fifo_empty;
  assign mem_wdata = mem_we ? fifo_dout : '0;
  assign mem_addr  = offset_q + ADDR_WIDTH'(wr_cnt);
  assign busy      = (state == ST_RUN) || (state == ST_FINISH);
  assign done      = (state == ST_FINISH);
  assign acc_fire  = acc_valid && acc_ready;
  assign wr_fire   = mem_we && mem_ready;

  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (acc_fire),
    .din   (result),
    .pop   (wr_fire),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The run ends on the write that brings wr_cnt up to the latched count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      offset_q <= '0;
      count_q  <= '0;
      bias_q   <= '0;
      shift_q  <= '0;
      acc_cnt  <= '0;
      wr_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            offset_q <= output_memory_offset;
            count_q  <= output_count;
            bias_q   <= filter_bias;
            shift_q  <= out_shift;
            acc_cnt  <= '0;
            wr_cnt   <= '0;
            state    <= (output_count == 16'd0) ? ST_FINISH : ST_RUN;
          end
        end
        ST_RUN: begin
          if (acc_fire) acc_cnt <= acc_cnt + 16'd1;
          if (wr_fire) begin
            wr_cnt <= wr_cnt + 16'd1;
            if (wr_cnt + 16'd1 == count_q) state <= ST_FINISH;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_writeback.sv
// Randomized self-checking bench for conv_writeback against a behavioural result/address model.
module tb_conv_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] output_memory_offset = '0;
  logic [15:0] output_count = '0;
  logic [17:0] filter_bias = '0;
  logic [3:0]  out_shift = '0;
  logic        acc_valid = 1'b0;
  logic [17:0] acc_data = '0;
  logic        acc_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic        done;

  int checks = 0;
  int passes = 0;
  int fails = 0;
  int cfg_offset, cfg_count, cfg_bias, cfg_shift;
  int wr_idx = 0;
  int acc_seen = 0;
  int done_cnt = 0;
  int last_addr = 0;
  int last_data = 0;
  int exp_q[$];

  conv_writeback dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .output_memory_offset (output_memory_offset),
    .output_count         (output_count),
    .filter_bias          (filter_bias),
    .out_shift            (out_shift),
    .acc_valid            (acc_valid),
    .acc_data             (acc_data),
    .acc_ready            (acc_ready),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_ready            (mem_ready),
    .busy                 (busy),
    .done                 (done)
  );

  always #5 clk = ~clk;

  function automatic int modelResult(int acc, int bias, int shift);
    int s;
    s = acc + bias;
    if (s < 0) return 0;
    s = s / (1 << shift);
    return (s > 255) ? 255 : s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue a start pulse with the given configuration, then scramble the config inputs.
  task automatic applyStimulus(input int offset, input int count, input int bias, input int shift);
    cfg_offset = offset;
    cfg_count  = count;
    cfg_bias   = bias;
    cfg_shift  = shift;
    wr_idx     = 0;
    acc_seen   = 0;
    exp_q.delete();
    output_memory_offset = 16'(offset);
    output_count         = 16'(count);
    filter_bias          = 18'(bias);
    out_shift            = 4'(shift);
    start                = 1'b1;
    @(posedge clk); #1;
    start                = 1'b0;
    output_memory_offset = 16'($urandom);
    output_count         = 16'($urandom);
    filter_bias          = 18'($urandom);
    out_shift            = 4'($urandom);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_acc_ready"}, 32'(acc_ready), 0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 0);
    checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic runStream(input int count, input int offset, input int bias, input int shift,
                           input bit fixed, input int fixed_val, input int ready_pct);
    int  d0;
    int  v;
    bit  finished;
    d0 = done_cnt;
    finished = 1'b0;
    applyStimulus(offset, count, bias, shift);
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      v = int'($urandom_range(0, 1500)) - 300;
      acc_valid = ($urandom_range(0, 3) != 0);
      acc_data  = fixed ? 18'(fixed_val) : 18'(v);
      mem_ready = ($urandom_range(0, 99) < ready_pct);
      start     = busy && ($urandom_range(0, 7) == 0);
      @(posedge clk); #1;
      if (done_cnt != d0) finished = 1'b1;
    end
    start = 1'b0;
    acc_valid = 1'b0;
    mem_ready = 1'b0;
    checkOutput("run_finished", 32'(finished), 1);
    checkOutput("run_writes", wr_idx, count);
    checkOutput("run_done_pulses", done_cnt - d0, 1);
    checkOutput("run_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    checkOutput("run_idle_busy", 32'(busy), 0);
    checkOutput("run_idle_done", 32'(done), 0);
  endtask

  // Observes every handshake between edges and scores writes against the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (acc_valid && acc_ready) begin
        checkOutput("acc_ready_allowed",
                    32'((acc_seen < cfg_count) && ((acc_seen - wr_idx) < 4)), 1);
        exp_q.push_back(modelResult(int'($signed(acc_data)), cfg_bias, cfg_shift));
        acc_seen++;
      end
      if (mem_we && mem_ready) begin
        checkOutput("write_has_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) checkOutput("wr_data", 32'(mem_wdata), exp_q.pop_front());
        checkOutput("wr_addr", 32'(mem_addr), (cfg_offset + wr_idx) & 32'hFFFF);
        last_addr = int'(mem_addr);
        last_data = int'(mem_wdata);
        wr_idx++;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    int  d0;
    bit  reached;
    int  r_count, r_offset, r_bias, r_shift, r_ready;

    // Reset, with a start pulse that reset must override.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    output_count = 16'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkIdleOutputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_start_ignored_busy", 32'(busy), 0);

    // Single result: (200+100)>>1 = 150 at 0x0040.
    acc_valid = 1'b1;
    acc_data  = 18'd200;
    mem_ready = 1'b1;
    applyStimulus(16'h0040, 1, 100, 1);
    checkOutput("single_acc_ready", 32'(acc_ready), 1);
    checkOutput("single_busy", 32'(busy), 1);
    checkOutput("single_we_early", 32'(mem_we), 0);
    @(posedge clk); #1;
    acc_valid = 1'b0;
    checkOutput("single_we", 32'(mem_we), 1);
    checkOutput("single_addr", 32'(mem_addr), 32'h0040);
    checkOutput("single_data", 32'(mem_wdata), 150);
    checkOutput("single_ready_after", 32'(acc_ready), 0);
    checkOutput("single_done_early", 32'(done), 0);
    @(posedge clk); #1;
    checkOutput("single_done", 32'(done), 1);
    checkOutput("single_finish_busy", 32'(busy), 1);
    checkOutput("single_finish_we", 32'(mem_we), 0);
    @(posedge clk); #1;
    checkOutput("single_done_off", 32'(done), 0);
    checkOutput("single_idle", 32'(busy), 0);
    mem_ready = 1'b0;

    // Clamping at both ends.
    runStream(1, 16'h0010, 100, 0, 1'b1, -150, 100);
    checkOutput("clamp_negative", last_data, 0);
    runStream(1, 16'h0011, 0, 0, 1'b1, 1000, 100);
    checkOutput("clamp_saturate", last_data, 255);

    // Back-pressure: FIFO fills after four transfers and outputs hold.
    acc_valid = 1'b1;
    mem_ready = 1'b0;
    acc_data  = 18'd77;
    d0 = done_cnt;
    applyStimulus(16'h0200, 8, 3, 0);
    for (int i = 2; i <= 11; i++) begin
      acc_data = 18'($urandom_range(0, 400));
      @(posedge clk); #1;
      if (i == 6 || i == 11) begin
        checkOutput("stall_we", 32'(mem_we), 1);
        checkOutput("stall_addr", 32'(mem_addr), 32'h0200);
        checkOutput("stall_data", 32'(mem_wdata), exp_q[0]);
      end
    end
    checkOutput("stall_transfers", acc_seen, 4);
    checkOutput("stall_acc_ready", 32'(acc_ready), 0);
    mem_ready = 1'b1;
    reached = 1'b0;
    for (int cyc = 0; cyc < 100 && !reached; cyc++) begin
      acc_data = 18'($urandom_range(0, 400));
      @(posedge clk); #1;
      if (done_cnt != d0) reached = 1'b1;
    end
    acc_valid = 1'b0;
    mem_ready = 1'b0;
    checkOutput("stall_done", 32'(reached), 1);
    checkOutput("stall_writes", wr_idx, 8);

    // Address wrap.
    runStream(3, 16'hFFFE, 50, 2, 1'b0, 0, 100);
    checkOutput("wrap_last_addr", last_addr, 0);

    // Zero-length run.
    acc_valid = 1'b1;
    d0 = done_cnt;
    applyStimulus(16'h0030, 0, 0, 0);
    checkOutput("zero_acc_ready", 32'(acc_ready), 0);
    checkOutput("zero_done", 32'(done), 1);
    checkOutput("zero_busy", 32'(busy), 1);
    checkOutput("zero_we", 32'(mem_we), 0);
    @(posedge clk); #1;
    checkOutput("zero_done_off", 32'(done), 0);
    checkOutput("zero_idle", 32'(busy), 0);
    checkOutput("zero_writes", wr_idx, 0);
    checkOutput("zero_done_pulses", done_cnt - d0, 1);

    // Abort after two of five writes.
    mem_ready = 1'b1;
    applyStimulus(16'h0020, 5, 10, 0);
    reached = 1'b0;
    for (int cyc = 0; cyc < 50 && !reached; cyc++) begin
      acc_data = 18'($urandom_range(0, 200));
      @(posedge clk); #1;
      if (wr_idx >= 2) reached = 1'b1;
    end
    checkOutput("abort_reached_two", 32'(reached), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    checkIdleOutputs("abort");
    rst = 1'b0;
    acc_valid = 1'b0;
    mem_ready = 1'b0;
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_no_done", done_cnt - d0, 0);
    checkOutput("abort_idle", 32'(busy), 0);
    runStream(3, 16'h0100, 0, 0, 1'b0, 0, 100);
    checkOutput("abort_restart_addr", last_addr, 32'h0102);

    // Randomized runs.
    for (int k = 0; k < 8; k++) begin
      r_count  = int'($urandom_range(1, 20));
      r_offset = int'($urandom_range(0, 65535));
      r_bias   = int'($urandom_range(0, 400)) - 200;
      r_shift  = int'($urandom_range(0, 4));
      r_ready  = int'($urandom_range(30, 100));
      runStream(r_count, r_offset, r_bias, r_shift, 1'b0, 0, r_ready);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
